// File: rtl/calcgame_round_ctrl.sv
// -----------------------------------------------------------------------------
// calcgame_round_ctrl
//
// Round sequencer for the calculator game. Walks the player through levels
// 1..3. For each level it loads the expected answer and the countdown, then
// runs a one-second timer from an internal tick divider. It judges the one-hot
// answer buttons on a submit edge, shows the result on the lamps for a hold
// period and keeps the running score.
//
// Ports
//   clk_i      system clock (single domain)
//   res_i      synchronous active-high reset
//   start_i    level input; a rising edge starts or restarts a game
//   submit_i   level input; a rising edge submits the current buttons
//   bi_i       answer buttons; bi_i[k] means value 6-k
//   q_ans_i    expected answer for the level on level_o (from the datapath)
//   level_o    0 = idle, 1..3 = active level (question select)
//   timer_o    seconds remaining
//   light_o    100 = wrong, 010 = correct, 001 = timeout, 000 = none
//   score_o    levels answered correctly (0..3)
//   done_o     game over
// -----------------------------------------------------------------------------
module calcgame_round_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int T_L1       = 30,
  parameter int T_L2       = 25,
  parameter int T_L3       = 20,
  parameter int HOLD_TICKS = 2
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       start_i,
  input  logic       submit_i,
  input  logic [6:0] bi_i,
  input  logic [3:0] q_ans_i,
  output logic [1:0] level_o,
  output logic [4:0] timer_o,
  output logic [2:0] light_o,
  output logic [1:0] score_o,
  output logic       done_o
);

  // A divider of one still needs a one-bit counter.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_TICKS - 1);

  localparam logic [2:0] LIGHT_NONE    = 3'b000;
  localparam logic [2:0] LIGHT_WRONG   = 3'b100;
  localparam logic [2:0] LIGHT_CORRECT = 3'b010;
  localparam logic [2:0] LIGHT_TIMEOUT = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ASK    = 3'd2,
    ST_RESULT = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       level_q, level_d;
  logic [4:0]       timer_q, timer_d;
  logic [2:0]       light_q, light_d;
  logic [1:0]       score_q, score_d;
  logic             done_q, done_d;
  logic [3:0]       ans_q, ans_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       hold_q, hold_d;
  logic             start_prev_q;
  logic             submit_prev_q;

  logic start_edge_s;
  logic submit_edge_s;
  logic tick_s;
  logic valid_sub_s;
  logic correct_s;
  logic expire_s;
  logic hold_done_s;

  // True when exactly one button is pressed.
  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  // Numeric value of the pressed button: bi[k] stands for 6-k.
  function automatic logic [3:0] bi_value(input logic [6:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < 7; k++) begin
      if (v[k]) begin
        r = 4'(6 - k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Countdown length in seconds for a given level.
  function automatic logic [4:0] level_time(input logic [1:0] lvl);
    logic [4:0] t;
    case (lvl)
      2'd1:    t = 5'(T_L1);
      2'd2:    t = 5'(T_L2);
      2'd3:    t = 5'(T_L3);
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  // The history registers come out of reset at 1, so an input held high
  // through reset produces no edge until it has dropped and risen again.
  assign start_edge_s  = start_i & ~start_prev_q;
  assign submit_edge_s = submit_i & ~submit_prev_q;

  // The divider only runs while a countdown or a result hold is in progress.
  assign tick_s      = ((state_q == ST_ASK) || (state_q == ST_RESULT)) && (div_q == DIV_MAX);
  assign valid_sub_s = (state_q == ST_ASK) && submit_edge_s && is_onehot7(bi_i);
  assign correct_s   = (bi_value(bi_i) == ans_q);
  assign expire_s    = (state_q == ST_ASK) && tick_s && (timer_q == 5'd1);
  assign hold_done_s = (state_q == ST_RESULT) && tick_s && (hold_q == HOLD_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      state_q       <= ST_IDLE;
      level_q       <= 2'd0;
      timer_q       <= 5'd0;
      light_q       <= LIGHT_NONE;
      score_q       <= 2'd0;
      done_q        <= 1'b0;
      ans_q         <= 4'd0;
      div_q         <= '0;
      hold_q        <= 4'd0;
      start_prev_q  <= 1'b1;
      submit_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      timer_q       <= timer_d;
      light_q       <= light_d;
      score_q       <= score_d;
      done_q        <= done_d;
      ans_q         <= ans_d;
      div_q         <= div_d;
      hold_q        <= hold_d;
      start_prev_q  <= start_i;
      submit_prev_q <= submit_i;
    end
  end

  // Next-state selection for the round sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_ASK;
      end
      ST_ASK: begin
        // A judged submit and an expiring tick both lead to RESULT.
        if (valid_sub_s || expire_s) begin
          state_d = ST_RESULT;
        end else begin
          state_d = ST_ASK;
        end
      end
      ST_RESULT: begin
        if (hold_done_s) begin
          if (level_q == 2'd3) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_RESULT;
        end
      end
      ST_OVER: begin
        if (start_edge_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, divider and hold counter.
  always_comb begin
    level_d = level_q;
    timer_d = timer_q;
    light_d = light_q;
    score_d = score_q;
    done_d  = done_q;
    ans_d   = ans_q;
    div_d   = div_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        // Both wait for a start edge, which begins a fresh game at level 1.
        if (start_edge_s) begin
          level_d = 2'd1;
          score_d = 2'd0;
          done_d  = 1'b0;
          light_d = LIGHT_NONE;
        end else begin
          level_d = level_q;
        end
      end
      ST_LOAD: begin
        // level_q has been stable for a cycle, so q_ans_i is settled here.
        ans_d   = q_ans_i;
        timer_d = level_time(level_q);
        light_d = LIGHT_NONE;
        div_d   = '0;
        hold_d  = 4'd0;
      end
      ST_ASK: begin
        if (tick_s) begin
          div_d = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (valid_sub_s) begin
          // A judged submit wins over a same-cycle tick: timer stays frozen.
          if (correct_s) begin
            light_d = LIGHT_CORRECT;
            score_d = score_q + 2'd1;
          end else begin
            light_d = LIGHT_WRONG;
          end
          div_d  = '0;
          hold_d = 4'd0;
        end else if (tick_s) begin
          if (timer_q == 5'd1) begin
            timer_d = 5'd0;
            light_d = LIGHT_TIMEOUT;
            hold_d  = 4'd0;
          end else if (timer_q != 5'd0) begin
            timer_d = timer_q - 5'd1;
          end else begin
            timer_d = timer_q;
          end
        end else begin
          timer_d = timer_q;
        end
      end
      ST_RESULT: begin
        if (tick_s) begin
          div_d = '0;
          if (hold_done_s) begin
            hold_d = 4'd0;
            if (level_q == 2'd3) begin
              done_d = 1'b1;
            end else begin
              level_d = level_q + 2'd1;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        level_d = 2'd0;
        timer_d = 5'd0;
        light_d = LIGHT_NONE;
        score_d = 2'd0;
        done_d  = 1'b0;
        div_d   = '0;
        hold_d  = 4'd0;
      end
    endcase
  end

  assign level_o = level_q;
  assign timer_o = timer_q;
  assign light_o = light_q;
  assign score_o = score_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_calcgame_round_ctrl.sv
// Bench for calcgame_round_ctrl: directed game scenarios followed by random
// button/start/submit traffic, every cycle compared with a behavioural model
// that tracks elapsed cycles per phase rather than divider/hold counters.
module tb_calcgame_round_ctrl;

  localparam int TD   = 4;
  localparam int HOLD = 2;
  localparam int TL   = 3;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_ASK    = 2;
  localparam int P_RESULT = 3;
  localparam int P_OVER   = 4;

  logic       clk;
  logic       res;
  logic       start;
  logic       submit;
  logic [6:0] bi;
  logic [3:0] q_ans;
  logic [1:0] level;
  logic [4:0] timer;
  logic [2:0] light;
  logic [1:0] score;
  logic       done;

  int n_cmp;
  int n_bad;

  // Reference model state
  int         m_phase;
  int         m_el;
  logic [1:0] m_level;
  logic [4:0] m_timer;
  logic [2:0] m_light;
  logic [1:0] m_score;
  logic       m_done;
  logic [3:0] m_ans;
  logic       m_ps;
  logic       m_pb;

  logic [3:0] ans_tab [0:3];

  calcgame_round_ctrl #(
    .TICK_DIV  (TD),
    .T_L1      (TL),
    .T_L2      (TL),
    .T_L3      (TL),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk_i   (clk),
    .res_i   (res),
    .start_i (start),
    .submit_i(submit),
    .bi_i    (bi),
    .q_ans_i (q_ans),
    .level_o (level),
    .timer_o (timer),
    .light_o (light),
    .score_o (score),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-hot button pattern for an answer value (zero if not representable).
  function automatic logic [6:0] btn_for(input logic [3:0] v);
    logic [6:0] one;
    one = 7'd1;
    if (v > 4'd6) return 7'd0;
    return one << (6 - int'(v));
  endfunction

  // Game rules applied to the inputs seen at one clock edge.
  task automatic model_step();
    logic se;
    logic sb;
    if (res) begin
      m_phase = P_IDLE; m_el = 0; m_level = 2'd0; m_timer = 5'd0;
      m_light = 3'b000; m_score = 2'd0; m_done = 1'b0; m_ans = 4'd0;
      m_ps = 1'b1; m_pb = 1'b1;
    end else begin
      se = start && !m_ps;
      sb = submit && !m_pb;
      case (m_phase)
        P_IDLE, P_OVER: begin
          if (se) begin
            m_level = 2'd1; m_score = 2'd0; m_done = 1'b0; m_light = 3'b000;
            m_phase = P_LOAD;
          end
        end
        P_LOAD: begin
          m_ans = q_ans; m_timer = 5'(TL); m_light = 3'b000; m_el = 0;
          m_phase = P_ASK;
        end
        P_ASK: begin
          m_el++;
          if (sb && $countones(bi) == 1) begin
            if (bi == btn_for(m_ans) && btn_for(m_ans) != 7'd0) begin
              m_light = 3'b010; m_score = m_score + 2'd1;
            end else begin
              m_light = 3'b100;
            end
            m_phase = P_RESULT; m_el = 0;
          end else begin
            m_timer = 5'(TL - m_el / TD);
            if (m_el == TL * TD) begin
              m_light = 3'b001; m_phase = P_RESULT; m_el = 0;
            end
          end
        end
        P_RESULT: begin
          m_el++;
          if (m_el == HOLD * TD) begin
            if (m_level == 2'd3) begin
              m_done = 1'b1; m_phase = P_OVER;
            end else begin
              m_level = m_level + 2'd1; m_phase = P_LOAD;
            end
          end
        end
        default: m_phase = P_IDLE;
      endcase
      m_ps = start;
      m_pb = submit;
    end
  endtask

  // Advance one clock, update the model, compare all outputs, drive q_ans.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("timer", 32'(timer), 32'(m_timer));
    chk("light", 32'(light), 32'(m_light));
    chk("score", 32'(score), 32'(m_score));
    chk("done",  32'(done),  32'(m_done));
    q_ans = ans_tab[m_level];
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int r;
    n_cmp = 0; n_bad = 0;
    res = 1'b1; start = 1'b1; submit = 1'b1; bi = 7'd0;
    ans_tab[0] = 4'd0; ans_tab[1] = 4'd1; ans_tab[2] = 4'd6;
    ans_tab[3] = 4'($urandom_range(0, 6));
    q_ans = 4'd0;
    m_phase = P_IDLE; m_el = 0; m_level = 2'd0; m_timer = 5'd0; m_light = 3'b000;
    m_score = 2'd0; m_done = 1'b0; m_ans = 4'd0; m_ps = 1'b1; m_pb = 1'b1;

    // Reset with start/submit held high, then release.
    ticks(3);
    res = 1'b0;
    ticks(3);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_timer", 32'(timer), 32'd0);
    chk("rst_light", 32'(light), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    submit = 1'b0;
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("start_level", 32'(level), 32'd1);
    tick();
    chk("l1_timer", 32'(timer), 32'd3);

    // Level 1: correct answer (value 1).
    bi = 7'b0100000; submit = 1'b1; tick();
    chk("ok_light", 32'(light), 32'b010);
    chk("ok_score", 32'(score), 32'd1);
    submit = 1'b0;
    ticks(8);
    chk("adv_level2", 32'(level), 32'd2);
    tick();
    chk("l2_timer", 32'(timer), 32'd3);

    // Level 2: multi-hot ignored, then wrong one-hot.
    bi = 7'b0000011; submit = 1'b1; tick();
    chk("multihot_light", 32'(light), 32'b000);
    chk("multihot_level", 32'(level), 32'd2);
    submit = 1'b0; tick();
    bi = 7'b0010000; submit = 1'b1; tick();
    chk("wrong_light", 32'(light), 32'b100);
    chk("wrong_score", 32'(score), 32'd1);
    submit = 1'b0;
    ticks(9);

    // Level 3: correct answer ends the game.
    bi = btn_for(ans_tab[3]); submit = 1'b1; tick();
    chk("l3_light", 32'(light), 32'b010);
    submit = 1'b0;
    ticks(8);
    chk("over_done",  32'(done),  32'd1);
    chk("over_score", 32'(score), 32'd2);
    chk("over_level", 32'(level), 32'd3);

    // Restart from OVER.
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("restart_level", 32'(level), 32'd1);
    chk("restart_score", 32'(score), 32'd0);
    chk("restart_done",  32'(done),  32'd0);
    chk("restart_light", 32'(light), 32'd0);
    tick();
    chk("to_t3", 32'(timer), 32'd3);

    // Level 1 timeout.
    ticks(4);
    chk("to_t2", 32'(timer), 32'd2);
    ticks(4);
    chk("to_t1", 32'(timer), 32'd1);
    ticks(3);
    chk("to_prelight", 32'(light), 32'd0);
    tick();
    chk("to_t0",    32'(timer), 32'd0);
    chk("to_light", 32'(light), 32'b001);
    chk("to_score", 32'(score), 32'd0);
    ticks(9);

    // Level 2: correct submit on the expiring tick.
    ticks(11);
    bi = btn_for(ans_tab[2]); submit = 1'b1; tick();
    chk("sim_light", 32'(light), 32'b010);
    chk("sim_timer", 32'(timer), 32'd1);
    chk("sim_score", 32'(score), 32'd1);
    submit = 1'b0;
    ticks(9);
    ticks(2);

    // Reset in ASK.
    res = 1'b1; tick();
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_timer", 32'(timer), 32'd0);
    chk("mid_rst_light", 32'(light), 32'd0);
    chk("mid_rst_score", 32'(score), 32'd0);
    res = 1'b0;

    // Random traffic against the model.
    for (int g = 1; g < 4; g++) ans_tab[g] = 4'($urandom_range(0, 7));
    for (int c = 0; c < 2000; c++) begin
      res = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) start = ~start;
      if ($urandom_range(0, 3) == 0) submit = ~submit;
      r = $urandom_range(0, 3);
      case (r)
        0:       bi = btn_for(ans_tab[m_level]);
        1:       bi = btn_for(4'($urandom_range(0, 6)));
        2:       bi = 7'($urandom);
        default: bi = 7'd0;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calcgame_round_ctrl.md
# calcgame_round_ctrl

Round sequencer for the calculator game. Walks the player through levels 1..3: loads each level's expected answer and countdown, runs the seconds timer from an internal tick divider, judges the one-hot answer buttons on a submit edge, then drives the result lamps and the running score. Sits between the button/switch inputs and the question/score display datapath. The datapath supplies the question and expected answer for the level this block selects.

## Interface
- TICK_DIV, 100_000_000: clk cycles per one-second tick.
- T_L1, 30: level-1 countdown in seconds (1..31).
- T_L2, 25: level-2 countdown in seconds (1..31).
- T_L3, 20: level-3 countdown in seconds (1..31).
- HOLD_TICKS, 2: seconds the result is held before advancing (1..15).
- clk  in  1  system clock; one clock domain.
- res  in  1  reset, synchronous, active-high.
- start  in  1  level input, rising edge starts/restarts a game.
- submit  in  1  level input, rising edge submits current bi.
- bi  in  7  answer buttons; bi[k] set means value 6-k (bi[6]=0 … bi[0]=6).
- q_ans  in  4  expected answer for the current `level`, from the question datapath.
- level  out  2  0 = idle, 1..3 = active level; drives question select.
- timer  out  5  seconds remaining.
- light  out  3  100 = wrong, 010 = correct, 001 = timeout, 000 = none.
- score  out  2  levels answered correctly (0..3).
- done  out  1  game over.

## Operation
- States: IDLE, LOAD, ASK, RESULT, OVER.
- Reset (res=1 at a clk edge):
  - state=IDLE; level, timer, light, score and done all 0.
  - Tick divider 0, hold counter 0.
  - start/submit edge-detect history registers set to 1, so an input held through reset does not fire.
- IDLE:
  - Outputs static.
  - start edge → LOAD; level←1, score←0.
- LOAD (exactly 1 cycle):
  - ans_reg←q_ans.
  - timer←T_L<level>.
  - Tick divider←0, light←000.
  - → ASK.
- ASK:
  - Divider counts 0..TICK_DIV-1; each wrap is a tick, and timer decrements by 1.
  - submit edge with bi exactly one-hot:
    - value==ans_reg: light←010, score←score+1, → RESULT.
    - Otherwise: light←100, → RESULT.
  - submit edge with bi zero or multi-hot: ignored, stay in ASK.
  - Tick while timer==1: timer←0, light←001, → RESULT.
  - Submit edge and expiring tick in the same cycle: the submit is judged; timer keeps its value of 1.
- RESULT:
  - light and timer frozen.
  - Counts HOLD_TICKS ticks (divider restarts at entry).
  - Then, if level==3: → OVER, done←1.
  - Else: level←level+1, → LOAD.
- OVER:
  - done=1; level, light and score held.
  - start edge → LOAD with level←1, score←0, done←0, light←000.
- A start edge in ASK, LOAD or RESULT is ignored.
- submit is ignored outside ASK.
- Score never exceeds 3; there is no wrap logic and none is required.
- TICK_DIV width: ceil(log2(TICK_DIV)) bits.
- A mid-operation res returns the block to IDLE in the next cycle from any state.

## Timing
- All outputs are registered.
- Edge detection: input sampled at edge n, with history from edge n-1.
- A start or submit first high at edge n updates its outputs after edge n, visible in cycle n+1.
- LOAD → ASK is 1 cycle. level is stable at least 1 cycle before q_ans is sampled in LOAD, so the datapath has one full cycle of combinational decode.
- Tick latency: the first tick in ASK comes TICK_DIV cycles after LOAD.
- Timeout: T_L<level>·TICK_DIV cycles after ASK entry.
- RESULT dwell: HOLD_TICKS·TICK_DIV cycles.
- done rises on the cycle after the final hold tick.

## Test plan
Bench uses TICK_DIV=4, HOLD_TICKS=2, T_L1=3, T_L2=3, T_L3=3.
- Reset/idle: hold res 3 cycles with start=1 and submit=1; release → level=0, timer=0, light=000, score=0, done=0, and no start fires until start drops and rises again.
- Correct answer: start edge, q_ans=1; in ASK set bi=7'b0100000 and pulse submit → next cycle light=010, score=1. After 8 cycles level=2 and timer=3.
- Wrong/invalid: at level 2 with q_ans=6, submit bi=7'b0000011 → ignored, still ASK. Then submit bi=7'b0010000 → light=100, score unchanged.
- Timeout: no submit at level 1 → timer reads 3,2,1,0 at 4-cycle spacing; light=001 in the cycle timer reaches 0; score stays 0.
- Simultaneous: submit correct on the exact cycle the timer 1→0 tick fires → light=010, timer stays 1, score increments.
- Full game and restart:
  - Correct, wrong, correct across levels 1..3 → done=1, score=2, level=3.
  - Start edge → LOAD, level=1, score=0, done=0.
  - Assert res in ASK → IDLE on the next cycle.
